// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one request at a time, word-aligned memory access with RMW sub-word stores.
// Define MEM_ACCESS_STATS_EN to add the stat_loads/stat_stores/stat_stalls/stat_errs counter ports.
module mem_access_ctrl #(
    parameter int TIMEOUT  = 255,
    parameter int MIN_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_stalls,
    output logic [31:0] stat_errs
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0] MIN_WAIT_C = 8'(MIN_WAIT);

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q, err_q;
    logic        write_q, unsigned_q;
    logic [7:0]  cnt;

    logic        misaligned, ready_ok, timed_out;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lane_ext, merged;

    // NOTE: every combinational variable gets a default first so no path infers a latch.
    always_comb begin
        misaligned = 1'b1;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // mem_ready is ignored until the phase has been held for MIN_WAIT cycles.
    assign ready_ok  = (cnt >= MIN_WAIT_C) && mem_ready;
    assign timed_out = !ready_ok && (cnt == TIMEOUT_C);

    always_comb begin
        byte_v   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        lane_ext = mem_rdata;
        merged   = mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                lane_ext = {{24{~unsigned_q & byte_v[7]}}, byte_v};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                lane_ext = {{16{~unsigned_q & half_v[15]}}, half_v};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // NOTE: reset is synchronous, so it is just the first branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)                             state_next = DONE;
                    else if (req_write && req_size == SZ_WORD)  state_next = WR;
                    else                                        state_next = RD;
                end
            end
            RD: begin
                if (ready_ok)       state_next = write_q ? WR : DONE;
                else if (timed_out) state_next = DONE;
            end
            WR: begin
                if (ready_ok || timed_out) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            err_q      <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            cnt        <= '0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if ((state == RD || state == WR) && cnt != TIMEOUT_C)
                cnt <= cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        rdata_q    <= '0;
                        err_q      <= misaligned ? ERR_MIS : ERR_OK;
                    end
                end
                RD: begin
                    if (ready_ok) begin
                        if (write_q) wdata_q <= merged;
                        else         rdata_q <= lane_ext;
                    end else if (timed_out) begin
                        err_q <= ERR_TO;
                    end
                end
                WR: begin
                    if (timed_out) err_q <= ERR_TO;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = ERR_OK;
        mem_addr   = '0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: stall = req_valid;
            RD: begin
                stall    = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
            end
            WR: begin
                stall     = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wdata_q;
                mem_write = ready_ok;
            end
            default: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
        endcase
    end

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_stalls <= '0;
            stat_errs   <= '0;
        end else begin
            if (stall) stat_stalls <= stat_stalls + 32'd1;
            if (state == DONE) begin
                if (err_q != ERR_OK) stat_errs   <= stat_errs + 32'd1;
                else if (write_q)    stat_stores <= stat_stores + 32'd1;
                else                 stat_loads  <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized requests against a
// word-array memory model; define MEM_ACCESS_STATS_EN to also check the statistics counters.
module tb_mem_access_ctrl;

    localparam int TIMEOUT  = 8;
    localparam int MIN_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, mem_write, mem_ready;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  resp_err;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_stalls, stat_errs;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .MIN_WAIT(MIN_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_stalls  (stat_stalls),
        .stat_errs    (stat_errs)
`endif
    );

    // dev_mem is the memory the DUT talks to; ref_mem is what it should contain.
    logic [31:0] dev_mem [64];
    logic [31:0] ref_mem [64];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_writes = 0;
    logic [31:0] last_waddr = '0;
    int          exp_loads, exp_stores, exp_errs, exp_stalls;

    assign mem_rdata = dev_mem[mem_addr[7:2]];

    always @(negedge clk) begin
        #2;
        if (mem_write === 1'b1) begin
            dev_mem[mem_addr[7:2]] = mem_wdata;
            n_writes++;
            last_waddr = mem_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        if (size == 2'b10) return word;
        if (size == 2'b00) begin
            v = (word >> (8 * addr[1:0])) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (word >> (16 * addr[1])) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] old, input logic [1:0] size,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        int          sh;
        logic [31:0] mask;
        if (size == 2'b10) return wdata;
        sh   = (size == 2'b00) ? 8 * addr[1:0] : 16 * addr[1];
        mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic check_stats(input string tag);
`ifdef MEM_ACCESS_STATS_EN
        check({tag, "_stat_loads"},  stat_loads,  32'(exp_loads));
        check({tag, "_stat_stores"}, stat_stores, 32'(exp_stores));
        check({tag, "_stat_stalls"}, stat_stalls, 32'(exp_stalls));
        check({tag, "_stat_errs"},   stat_errs,   32'(exp_errs));
`else
        if (tag.len() == 0) n_checks = n_checks + 0;
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"},      32'(stall),      32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
        check({tag, "_resp_err"},   32'(resp_err),   32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_mem_write"},  32'(mem_write),  32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        exp_loads = 0; exp_stores = 0; exp_errs = 0; exp_stalls = 0;
        check_quiet("reset");
        check_stats("reset");
        rst_n = 1'b1;
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready low for 'hold' cycles, 3 ready never.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int mode, input int hold,
                          output logic [31:0] rdata, output logic [1:0] err, output int lat);
        int          w;
        int          e_lat, wr_before, stalls, zeros;
        logic        got;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        w       = int'(addr[7:2]);
        e_err   = is_mis(size, addr) ? 2'b01 : (mode == 3 ? 2'b10 : 2'b00);
        e_rdata = (e_err == 2'b00 && !wr) ? load_model(ref_mem[w], size, uns, addr) : 32'd0;
        if (e_err == 2'b01)              e_lat = 1;
        else if (mode == 3)              e_lat = TIMEOUT + 2;
        else if (wr && size != 2'b10)    e_lat = 1 + 2 * (MIN_WAIT + 1);
        else                             e_lat = MIN_WAIT + 2;
        wr_before = n_writes;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        lat = 0; stalls = 0; zeros = 0; got = 1'b0; rdata = '0; err = '0;
        while (!got && lat < 40) begin
            case (mode)
                0: mem_ready = 1'b1;
                1: begin
                    if (zeros >= 3 || $urandom_range(0, 3) != 0) begin
                        mem_ready = 1'b1; zeros = 0;
                    end else begin
                        mem_ready = 1'b0; zeros++;
                    end
                end
                2: mem_ready = (lat >= hold);
                default: mem_ready = 1'b0;
            endcase
            #1;
            if (stall) stalls++;
            if (resp_valid) begin
                got = 1'b1; rdata = resp_rdata; err = resp_err;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check("resp_seen", 32'(got), 32'd1);
        check("resp_err", 32'(err), 32'(e_err));
        check("resp_rdata", rdata, e_rdata);
        check("stall_cycles", 32'(stalls), 32'(lat));
        if (mode == 0 || mode == 3) check("latency", 32'(lat), 32'(e_lat));
        check("write_count", 32'(n_writes - wr_before), (e_err == 2'b00 && wr) ? 32'd1 : 32'd0);
        if (e_err == 2'b00 && wr) begin
            ref_mem[w] = store_model(ref_mem[w], size, addr, wdata);
            check("write_addr", last_waddr, {addr[31:2], 2'b00});
        end
        check("mem_word", dev_mem[w], ref_mem[w]);
        exp_stalls += lat;
        if (e_err != 2'b00) exp_errs++;
        else if (wr)        exp_stores++;
        else                exp_loads++;
    endtask

    // Starts a byte store and pulls reset in cycle k after acceptance (2 = still in RD, 3 = in WR).
    task automatic abort_rmw(input logic [31:0] addr, input logic [31:0] wdata, input int k, input string tag);
        int w, wr_before;
        w         = int'(addr[7:2]);
        wr_before = n_writes;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = wdata; mem_ready = 1'b1;
        repeat (k) @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        #1;
        exp_loads = 0; exp_stores = 0; exp_errs = 0; exp_stalls = 0;
        check_quiet(tag);
        check_stats(tag);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_writes"}, 32'(n_writes - wr_before), 32'd0);
        check({tag, "_mem"}, dev_mem[w], ref_mem[w]);
    endtask

    logic [31:0] rd, a, d;
    logic [1:0]  er, sz;
    int          lat;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        do_reset();

        // Word round trip.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0, rd, er, lat);
        check("t1_waddr", last_waddr, 32'h10);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, rd, er, lat);
        check("t1_lw", rd, 32'hDEAD_BEEF);

        // Byte store merge and byte load signedness.
        dev_mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h5555_55AA, 0, 0, rd, er, lat);
        check("t2_merge", dev_mem[8], 32'h1122_AA44);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, 0, rd, er, lat);
        check("t2_lb", rd, 32'hFFFF_FFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, 0, rd, er, lat);
        check("t2_lbu", rd, 32'h0000_00AA);

        // Half load signedness.
        dev_mem[12] = 32'h8001_7FFF; ref_mem[12] = 32'h8001_7FFF;
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0, 0, rd, er, lat);
        check("t3_lh_hi", rd, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 0, 0, rd, er, lat);
        check("t3_lhu_hi", rd, 32'h0000_8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 0, 0, rd, er, lat);
        check("t3_lh_lo", rd, 32'h0000_7FFF);

        // Misaligned and illegal size.
        do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 0, rd, er, lat);
        check("t4_lw_err", 32'(er), 32'd1);
        do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234_5678, 0, 0, rd, er, lat);
        check("t4_sh_err", 32'(er), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, 0, rd, er, lat);

        // Slow memory, then no ready at all.
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 4, rd, er, lat);
        check("t5_slow_lat", 32'(lat), 32'd5);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 0, rd, er, lat);
        do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, 3, 0, rd, er, lat);
        do_req(1'b1, 2'b00, 1'b0, 32'h1D, 32'h0000_0077, 3, 0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check_stats("directed");

        // Reset in the middle of a read-modify-write.
        abort_rmw(32'h21, 32'h0000_0099, 2, "t6_rd");
        abort_rmw(32'h22, 32'h0000_0066, 3, "t6_wr");

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    sz = 2'b00;
                2, 3:    sz = 2'b01;
                7:       sz = 2'b11;
                default: sz = 2'b10;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'b01) ? ~32'd1 : (sz == 2'b10) ? ~32'd3 : ~32'd0);
            d = $urandom;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d,
                   int'($urandom_range(0, 1)), 0, rd, er, lat);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check_stats("random");
        for (int i = 0; i < 64; i++) check("final_mem", dev_mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
